// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM encoding
// and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-macro signal bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, ack0, ack1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, ack0, ack1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a tie goes to the
// requester that did not win last time.
import mem_arbiter_pkg::*;

module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CORE;
        unique case (1'b1)
            (req0 && req1):  winner = ~last_winner;
            (req1 && !req0): winner = REQ_LOADER;
            default:         winner = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Core/loader arbiter for the shared memory macro: one access per
// IDLE -> ACCESS -> RESP pass, round-robin on ties.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state_q;
    state_t            state_d;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_q;
    logic              pick_valid;
    logic              pick_winner;

    rr_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_winner (last_q),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured only on the IDLE decision edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q   <= REQ_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= REQ_LOADER;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                win_q <= pick_winner;
                if (pick_winner == REQ_LOADER) begin
                    we_q    <= bus.we1;
                    addr_q  <= bus.addr1;
                    wdata_q <= bus.wdata1;
                end else begin
                    we_q    <= bus.we0;
                    addr_q  <= bus.addr0;
                    wdata_q <= bus.wdata0;
                end
            end
            if (state_q == RESP) begin
                last_q <= win_q;
            end
        end
    end

    logic busy;
    logic in_access;
    logic in_resp;

    assign busy      = (state_q != IDLE);
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign bus.gnt0 = busy && (win_q == REQ_CORE);
    assign bus.gnt1 = busy && (win_q == REQ_LOADER);
    assign bus.ack0 = in_resp && (win_q == REQ_CORE);
    assign bus.ack1 = in_resp && (win_q == REQ_LOADER);

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Synchronous macro output passes straight through during RESP
    assign bus.rdata = (in_resp && !we_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory
// macro and an expected-ack scoreboard.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [logic [31:0]];
    int          tests = 0;
    int          fails = 0;
    logic        prev_en = 1'b0;

    // Synchronous memory: read data appears the cycle after mem_en
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_rdata <= mem.exists(bus.mem_addr) ?
                                 mem[bus.mem_addr] : 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            tests++;
            if ((bus.gnt0 && bus.gnt1) || (bus.ack0 && bus.ack1)) begin
                fails++;
                $display("FAIL onehot gnt=%b%b ack=%b%b required at most one",
                         bus.gnt1, bus.gnt0, bus.ack1, bus.ack0);
            end
            if ((bus.ack0 || bus.ack1) && !prev_en) begin
                tests++;
                fails++;
                $display("FAIL ack_no_access ack=%b%b without prior mem_en",
                         bus.ack1, bus.ack0);
            end
        end
        prev_en = rst ? bus.mem_en : 1'b0;
    end

    task automatic wait_ack(output logic got, output logic id,
                            output int cyc);
        got = 1'b0;
        id  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got = 1'b1;
                id  = bus.ack1;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
             bus.mem_en, bus.mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b required 000000",
                     {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
                      bus.mem_en, bus.mem_we});
        end
        tests++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
            bus.rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h required 0",
                     bus.mem_addr, bus.mem_wdata, bus.rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_core_read();
        exp_t e;
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'h10;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL read_access en=%b we=%b addr=%h required 1 0 10",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tests++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.ack0 !== 1'b0) begin
            fails++;
            $display("FAIL read_gnt gnt0=%b gnt1=%b ack0=%b required 1 0 0",
                     bus.gnt0, bus.gnt1, bus.ack0);
        end
        @(negedge clk);
        e = sb.pop_front();
        tests++;
        if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL read_ack ack0=%b ack1=%b gnt1=%b required 1 0 0",
                     bus.ack0, bus.ack1, bus.gnt1);
        end
        tests++;
        if (bus.rdata !== e.data) begin
            fails++;
            $display("FAIL read_data got %h required %h", bus.rdata, e.data);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ack0 !== 1'b0 || bus.mem_en !== 1'b0 || bus.gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL read_done ack0=%b en=%b gnt0=%b required 0 0 0",
                     bus.ack0, bus.mem_en, bus.gnt0);
        end
    endtask

    task automatic test_loader_write();
        exp_t e;
        bus.req1   = 1'b1;
        bus.we1    = 1'b1;
        bus.addr1  = 32'h20;
        bus.wdata1 = 32'h12345678;
        sb.push_back('{1'b1, 32'h0});
        @(negedge clk);
        tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin
            fails++;
            $display("FAIL write_access en=%b we=%b addr=%h wdata=%h required 1 1 20 12345678",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL write_gnt gnt1=%b gnt0=%b required 1 0",
                     bus.gnt1, bus.gnt0);
        end
        @(negedge clk);
        e = sb.pop_front();
        tests++;
        if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.rdata !== e.data) begin
            fails++;
            $display("FAIL write_ack ack1=%b ack0=%b rdata=%h required 1 0 %h",
                     bus.ack1, bus.ack0, bus.rdata, e.data);
        end
        bus.req1 = 1'b0;
        bus.we1  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic got;
        logic id;
        int   cyc;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.addr0 = 32'h10;
        bus.addr1 = 32'h20;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b1, 32'h12345678});
        sb.push_back('{1'b0, 32'hDEADBEEF});
        for (int k = 0; k < 3; k++) begin
            wait_ack(got, id, cyc);
            e = sb.pop_front();
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL b2b_timeout k=%0d no ack within 8 cycles", k);
                break;
            end
            if (id !== e.id || bus.rdata !== e.data) begin
                fails++;
                $display("FAIL b2b_order k=%0d got id=%b data=%h required id=%b data=%h",
                         k, id, bus.rdata, e.id, e.data);
            end
            tests++;
            if (cyc != ((k == 0) ? 2 : 3)) begin
                fails++;
                $display("FAIL b2b_spacing k=%0d got %0d cycles required %0d",
                         k, cyc, (k == 0) ? 2 : 3);
            end
        end
        sb.delete();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_input_change();
        exp_t e;
        logic got;
        logic id;
        int   cyc;
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'h10;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        bus.addr0 = 32'h44;
        #1;
        tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL chg_access en=%b addr=%h required 1 10",
                     bus.mem_en, bus.mem_addr);
        end
        wait_ack(got, id, cyc);
        e = sb.pop_front();
        tests++;
        if (!got || id !== e.id || bus.rdata !== e.data || cyc != 1) begin
            fails++;
            $display("FAIL chg_ack got=%b id=%b data=%h cyc=%0d required 1 %b %h 1",
                     got, id, bus.rdata, cyc, e.id, e.data);
        end
        bus.req0  = 1'b0;
        bus.addr0 = 32'h10;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        logic got;
        logic id;
        int   cyc;
        int   seen;
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'h10;
        @(negedge clk);
        tests++;
        if (bus.mem_en !== 1'b1 || bus.gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre en=%b gnt0=%b required 1 1",
                     bus.mem_en, bus.gnt0);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (bus.mem_en !== 1'b0 || bus.gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_drop en=%b gnt0=%b required 0 0",
                     bus.mem_en, bus.gnt0);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.gnt0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rstmid_noack got %0d ack/gnt cycles required 0", seen);
        end
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr1 = 32'h20;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        wait_ack(got, id, cyc);
        e = sb.pop_front();
        tests++;
        if (!got || id !== e.id || bus.rdata !== e.data || cyc != 2) begin
            fails++;
            $display("FAIL rstmid_tie got=%b id=%b data=%h cyc=%0d required 1 %b %h 2",
                     got, id, bus.rdata, cyc, e.id, e.data);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({bus.mem_en, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1} !== 5'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet got %0d active cycles required 0", bad);
        end
    endtask

    initial begin
        bus.mem_rdata = '0;
        mem[32'h10] = 32'hDEADBEEF;
        clear_inputs();
        test_reset();
        test_core_read();
        test_loader_write();
        test_back_to_back();
        test_input_change();
        test_reset_mid_access();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
